// File: rtl/modn_updown_counter_if.sv
// Control/status bundle for modn_updown_counter.
// The master drives the controls and the counter (slave) drives the count and status.
interface modn_updown_counter_if #(
  parameter int WIDTH = 4,
  parameter int WCW   = 8
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] c;
  logic             tc;
  logic             wrap;
  logic             ld_err;
  logic [WCW-1:0]   wraps;

  modport master (
    output en, up, load, in,
    input  c, tc, wrap, ld_err, wraps
  );

  modport slave (
    input  en, up, load, in,
    output c, tc, wrap, ld_err, wraps
  );
endinterface

// File: rtl/modn_updown_counter.sv
// Modulo-MOD up/down counter with enable, clamped parallel load, cascade
// terminal count and a saturating wrap-event counter.
module modn_updown_counter #(
  parameter int MOD   = 12,
  parameter int WIDTH = 4,
  parameter int WCW   = 8
) (
  input logic                  clk,
  input logic                  rst,
  modn_updown_counter_if.slave bus
);

  if (MOD < 2) begin : g_bad_mod
    $error("modn_updown_counter: MOD must be >= 2");
  end
  if ((2 ** WIDTH) < MOD) begin : g_bad_width
    $error("modn_updown_counter: WIDTH too small for MOD");
  end

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] c_q;
  logic             wrap_q;
  logic             ld_err_q;
  logic [WCW-1:0]   wraps_q;
  logic             at_top;
  logic             at_bot;
  logic             tc_int;

  assign at_top = (c_q == MAX);
  assign at_bot = (c_q == '0);
  // Combinational so a chained stage sees the carry on the same edge.
  assign tc_int = bus.en & ~bus.load & ((bus.up & at_top) | (~bus.up & at_bot));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q      <= '0;
      wrap_q   <= 1'b0;
      ld_err_q <= 1'b0;
      wraps_q  <= '0;
    end else if (bus.load) begin
      if (bus.in > MAX) begin
        c_q      <= MAX;
        ld_err_q <= 1'b1;
      end else begin
        c_q      <= bus.in;
        ld_err_q <= 1'b0;
      end
      wrap_q  <= 1'b0;
      wraps_q <= '0;
    end else begin
      ld_err_q <= 1'b0;
      wrap_q   <= tc_int;
      if (tc_int && !(&wraps_q)) begin
        wraps_q <= wraps_q + 1'b1;
      end
      if (bus.en) begin
        if (bus.up) begin
          c_q <= at_top ? '0 : c_q + 1'b1;
        end else begin
          c_q <= at_bot ? MAX : c_q - 1'b1;
        end
      end
    end
  end

  assign bus.c      = c_q;
  assign bus.tc     = tc_int;
  assign bus.wrap   = wrap_q;
  assign bus.ld_err = ld_err_q;
  assign bus.wraps  = wraps_q;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter (MOD=12) including a two-stage chain.
module tb_modn_updown_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  modn_updown_counter_if #(.WIDTH(4), .WCW(8)) bus_a  ();
  modn_updown_counter_if #(.WIDTH(4), .WCW(8)) bus_lo ();
  modn_updown_counter_if #(.WIDTH(4), .WCW(8)) bus_hi ();

  modn_updown_counter #(.MOD(12), .WIDTH(4), .WCW(8)) dut    (.clk(clk), .rst(rst), .bus(bus_a));
  modn_updown_counter #(.MOD(12), .WIDTH(4), .WCW(8)) dut_lo (.clk(clk), .rst(rst), .bus(bus_lo));
  modn_updown_counter #(.MOD(12), .WIDTH(4), .WCW(8)) dut_hi (.clk(clk), .rst(rst), .bus(bus_hi));

  assign bus_hi.en = bus_lo.tc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int up_seq [8] = '{6, 7, 8, 9, 10, 11, 0, 1};
  int dn_seq [3] = '{0, 11, 10};

  initial begin
    bus_a.en = 0; bus_a.up = 1; bus_a.load = 0; bus_a.in = '0;
    bus_lo.en = 0; bus_lo.up = 1; bus_lo.load = 0; bus_lo.in = '0;
    bus_hi.up = 1; bus_hi.load = 0; bus_hi.in = '0;

    repeat (2) step();
    chk("rst_c", bus_a.c, 0);
    chk("rst_wrap", bus_a.wrap, 0);
    chk("rst_ld_err", bus_a.ld_err, 0);
    chk("rst_wraps", bus_a.wraps, 0);
    rst = 0;

    // 1: async reset mid-count at c=7
    bus_a.load = 1; bus_a.in = 4'd5; step();
    bus_a.load = 0; bus_a.en = 1; bus_a.up = 1;
    repeat (2) step();
    chk("t1_pre_c", bus_a.c, 7);
    bus_a.en = 0;
    #3 rst = 1;
    #1;
    chk("t1_async_c", bus_a.c, 0);
    chk("t1_async_wraps", bus_a.wraps, 0);
    #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_hold_c", bus_a.c, 0);
    end

    // 2: load 5, count up 8
    bus_a.load = 1; bus_a.in = 4'd5; step();
    bus_a.load = 0;
    chk("t2_load_c", bus_a.c, 5);
    chk("t2_load_ld_err", bus_a.ld_err, 0);
    bus_a.en = 1; bus_a.up = 1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_tc", bus_a.tc, (i == 6));
      step();
      chk("t2_c", bus_a.c, up_seq[i]);
      chk("t2_wrap", bus_a.wrap, (i == 6));
    end
    chk("t2_wraps", bus_a.wraps, 1);

    // 3: count down 3 from 1
    bus_a.up = 0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_tc", bus_a.tc, (i == 1));
      step();
      chk("t3_c", bus_a.c, dn_seq[i]);
      chk("t3_wrap", bus_a.wrap, (i == 1));
    end
    chk("t3_wraps", bus_a.wraps, 2);
    bus_a.en = 0;
    step();
    chk("t3_hold_c", bus_a.c, 10);
    chk("t3_hold_wrap", bus_a.wrap, 0);

    // 4: out-of-range load clamps, then legal load
    bus_a.load = 1; bus_a.in = 4'd14; step();
    chk("t4_clamp_c", bus_a.c, 11);
    chk("t4_ld_err", bus_a.ld_err, 1);
    chk("t4_wraps", bus_a.wraps, 0);
    bus_a.in = 4'd9; step();
    chk("t4_load9_c", bus_a.c, 9);
    chk("t4_load9_ld_err", bus_a.ld_err, 0);
    bus_a.load = 0; step();
    chk("t4_idle_ld_err", bus_a.ld_err, 0);

    // 5: load beats en at terminal count
    bus_a.load = 1; bus_a.in = 4'd11; step();
    bus_a.en = 1; bus_a.up = 1; bus_a.in = 4'd3;
    #1;
    chk("t5_tc", bus_a.tc, 0);
    step();
    chk("t5_c", bus_a.c, 3);
    chk("t5_wrap", bus_a.wrap, 0);
    chk("t5_wraps", bus_a.wraps, 0);

    // direction change at 0 goes straight to MOD-1
    bus_a.in = 4'd0; step();
    bus_a.load = 0; bus_a.up = 0;
    #1;
    chk("dir_tc", bus_a.tc, 1);
    step();
    chk("dir_c", bus_a.c, 11);
    chk("dir_wrap", bus_a.wrap, 1);
    bus_a.en = 0;

    // 6a: chained pair, 144 clocks
    bus_lo.en = 1;
    repeat (12) step();
    chk("t6_mid_lo_c", bus_lo.c, 0);
    chk("t6_mid_hi_c", bus_hi.c, 1);
    repeat (132) step();
    bus_lo.en = 0;
    chk("t6_lo_c", bus_lo.c, 0);
    chk("t6_hi_c", bus_hi.c, 0);
    chk("t6_hi_wraps", bus_hi.wraps, 1);
    chk("t6_lo_wraps", bus_lo.wraps, 12);

    // 6b: wrap counter saturation
    bus_a.load = 1; bus_a.in = 4'd0; step();
    bus_a.load = 0; bus_a.en = 1; bus_a.up = 1;
    repeat (12 * 255) step();
    chk("t6_sat_c", bus_a.c, 0);
    chk("t6_sat_wraps", bus_a.wraps, 255);
    repeat (12) step();
    chk("t6_sat_hold_wraps", bus_a.wraps, 255);
    chk("t6_sat_wrap", bus_a.wrap, 1);
    bus_a.en = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
